// File: rtl/tpu_pkg.sv
// Shared TPU definitions: array geometry and the activation feeder FSM encoding.
// Used by the unified buffer, the systolic array and the activation feeder.
package tpu_pkg;

    localparam int TPU_N      = 2;
    localparam int TPU_DATA_W = 32;
    localparam int TPU_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// One row lane of the skewed activation stream.
// Row ROW shows tile[ROW][t-ROW] while that column index is inside the tile, and zero otherwise.
module skew_lane #(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    parameter int ROW    = 0,
    parameter int T_W    = 2
) (
    input  logic [T_W-1:0]      t,
    input  logic [N*DATA_W-1:0] tile_row,
    output logic [DATA_W-1:0]   lane_data,
    output logic                lane_valid
);

    always_comb begin
        lane_data  = '0;
        lane_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (int'(t) == ROW + c) begin
                lane_data  = tile_row[c*DATA_W +: DATA_W];
                lane_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/activation_feeder.sv
// Loads an NxN activation tile from the unified buffer and streams it diagonally skewed into the array.
// Optional column-major load (transposed tile) is enabled with `define ACT_FEEDER_TRANSPOSE_EN.
//
// Handshake: start is a one-cycle request honoured only while the FSM is IDLE; requests at any
// other time are dropped, never queued. row_valid[r] qualifies lane r; done pulses once per tile.
module activation_feeder
    import tpu_pkg::*;
#(
    parameter int N      = TPU_N,
    parameter int DATA_W = TPU_DATA_W,
    parameter int ADDR_W = TPU_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
`ifdef ACT_FEEDER_TRANSPOSE_EN
    input  logic                transpose,
`endif
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [N*DATA_W-1:0] row_data,
    output logic [N-1:0]        row_valid,
    output logic                busy,
    output logic                done,
    output feeder_state_t       state
);

    localparam int K_W  = $clog2(N*N);
    localparam int T_W  = $clog2(2*N);
    localparam int RC_W = $clog2(N);

    logic [ADDR_W-1:0]   base_q;
    logic [K_W-1:0]      k;
    logic [T_W-1:0]      t;
    logic [N*DATA_W-1:0] tile_q [N];
    logic [RC_W-1:0]     ld_row;
    logic [RC_W-1:0]     ld_col;
    logic [N*DATA_W-1:0] row_next;
    logic [N-1:0]        valid_next;

    // Read address comes straight from the load counter so rd_data lands in the same cycle.
    assign rd_addr = base_q + ADDR_W'(k);

`ifdef ACT_FEEDER_TRANSPOSE_EN
    logic transpose_q;

    always_comb begin
        ld_row = RC_W'(k / K_W'(N));
        ld_col = RC_W'(k % K_W'(N));
        if (transpose_q) begin
            ld_row = RC_W'(k % K_W'(N));
            ld_col = RC_W'(k / K_W'(N));
        end
    end
`else
    always_comb begin
        ld_row = RC_W'(k / K_W'(N));
        ld_col = RC_W'(k % K_W'(N));
    end
`endif

    for (genvar r = 0; r < N; r++) begin : g_lane
        skew_lane #(
            .N      (N),
            .DATA_W (DATA_W),
            .ROW    (r),
            .T_W    (T_W)
        ) u_lane (
            .t          (t),
            .tile_row   (tile_q[r]),
            .lane_data  (row_next[r*DATA_W +: DATA_W]),
            .lane_valid (valid_next[r])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            base_q    <= '0;
            k         <= '0;
            t         <= '0;
            row_data  <= '0;
            row_valid <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ACT_FEEDER_TRANSPOSE_EN
            transpose_q <= 1'b0;
`endif
            for (int r = 0; r < N; r++) begin
                tile_q[r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    row_data  <= '0;
                    row_valid <= '0;
                    if (start) begin
                        base_q <= base_addr;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= LOAD;
`ifdef ACT_FEEDER_TRANSPOSE_EN
                        transpose_q <= transpose;
`endif
                    end
                end
                LOAD: begin
                    tile_q[ld_row][int'(ld_col)*DATA_W +: DATA_W] <= rd_data;
                    if (k == K_W'(N*N-1)) begin
                        t     <= '0;
                        state <= STREAM;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                STREAM: begin
                    row_data  <= row_next;
                    row_valid <= valid_next;
                    if (t == T_W'(2*N-2)) begin
                        state <= DONE;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                DONE: begin
                    // busy drops together with the done pulse so a start seen next cycle is legal.
                    row_data  <= '0;
                    row_valid <= '0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_feeder.sv
// Scoreboarded bench for activation_feeder: a reference model fills an expected-beat queue,
// a negedge monitor pops and compares every beat and done pulse the DUT presents.
module tb_activation_feeder;
    import tpu_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int EW = N + N*DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic [N*DW-1:0] row_data;
    logic [N-1:0]    row_valid;
    logic            busy;
    logic            done;
    feeder_state_t   state;
`ifdef ACT_FEEDER_TRANSPOSE_EN
    logic            transpose;
`endif

    logic [DW-1:0] mem [64];
    logic [EW-1:0] exp_q [$];
    int            exp_done_n = 0;
    int            checks = 0;
    int            errors = 0;

    assign rd_data = mem[rd_addr];

    activation_feeder #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
`ifdef ACT_FEEDER_TRANSPOSE_EN
        .transpose (transpose),
`endif
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .row_data  (row_data),
        .row_valid (row_valid),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tile[r][c] from the buffer, then beat t shows tile[r][t-r] on row r.
    task automatic push_tile(input int base, input bit tr, input int nbeats);
        logic [DW-1:0] tl [N][N];
        logic [EW-1:0] e;
        int r, c, j;
        for (int kk = 0; kk < N*N; kk++) begin
            r = tr ? kk % N : kk / N;
            c = tr ? kk / N : kk % N;
            tl[r][c] = mem[(base + kk) % 64];
        end
        for (int tt = 0; tt < nbeats; tt++) begin
            e = '0;
            for (int rr = 0; rr < N; rr++) begin
                j = tt - rr;
                if (j >= 0 && j < N) begin
                    e[N*DW + rr]      = 1'b1;
                    e[rr*DW +: DW]    = tl[rr][j];
                end
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if ((|row_valid) === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", {row_valid, row_data});
            end else begin
                e = exp_q.pop_front();
                if ({row_valid, row_data} !== e) begin
                    errors++;
                    $display("FAIL beat: got %0h expected %0h at %0t", {row_valid, row_data}, e, $time);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_done_n == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
            end else begin
                exp_done_n--;
            end
            check("valid_at_done", 64'(row_valid), 64'(0));
        end
    end

    // Driver: called at a negedge; returns at the negedge where done is visible.
    task automatic run_tile(input int base, input bit tr, input bit hold);
        int  n;
        bit  seen;
        start     = 1'b1;
        base_addr = AW'(base);
`ifdef ACT_FEEDER_TRANSPOSE_EN
        transpose = tr;
`endif
        push_tile(base, tr, 2*N-1);
        exp_done_n++;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int kk = 0; kk < N*N; kk++) begin
            @(negedge clk);
            check("rd_addr", 64'(rd_addr), 64'((base + kk) % 64));
            if (kk == 0) check("busy_in_load", 64'(busy), 64'(1));
        end
        @(negedge clk);
        n = N*N + 1;
        check("quiet_before_stream", 64'(row_valid), 64'(0));
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_latency", 64'(n), 64'(1 + N*N + 2*N));
        check("busy_with_done", 64'(busy), 64'(0));
        if (hold) start = 1'b0;
    endtask

    task automatic reset_mid_stream(input int base);
        start     = 1'b1;
        base_addr = AW'(base);
`ifdef ACT_FEEDER_TRANSPOSE_EN
        transpose = 1'b0;
`endif
        push_tile(base, 1'b0, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (N*N + 3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(row_valid), 64'(0));
        check("abort_data",  row_data, 64'(0));
        check("abort_busy",  64'(busy), 64'(0));
        check("abort_done",  64'(done), 64'(0));
        check("abort_state", 64'(state), 64'(IDLE));
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_abort", 64'(busy), 64'(0));
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
`ifdef ACT_FEEDER_TRANSPOSE_EN
        transpose = 1'b0;
`endif
        for (int a = 0; a < 64; a++) mem[a] = '0;
        mem[6'h1E] = 32'd11;
        mem[6'h1F] = 32'd12;
        mem[6'h20] = 32'd21;
        mem[6'h21] = 32'd22;
        repeat (3) @(negedge clk);
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        check("rst_row_data", row_data, 64'(0));
        check("rst_row_valid", 64'(row_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_state", 64'(state), 64'(IDLE));
        reset = 1'b1;
        @(negedge clk);

        run_tile(6'h1E, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'(0));

        run_tile(6'h1E, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("no_requeue", 64'(busy), 64'(0));

        mem[6'h3E] = 32'd1;
        mem[6'h3F] = 32'd2;
        mem[6'h00] = 32'd3;
        mem[6'h01] = 32'd4;
        run_tile(6'h3E, 1'b0, 1'b0);
        @(negedge clk);

        reset_mid_stream(6'h1E);
        run_tile(6'h1E, 1'b0, 1'b0);

        run_tile(6'h1E, 1'b0, 1'b0);
        run_tile(6'h1E, 1'b0, 1'b0);
        @(negedge clk);

`ifdef ACT_FEEDER_TRANSPOSE_EN
        run_tile(6'h1E, 1'b1, 1'b0);
        @(negedge clk);
`endif

        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 64; a++) mem[a] = $urandom;
            run_tile($urandom_range(0, 63), 1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (busy === 1'b1) @(negedge clk);
        end
`ifdef ACT_FEEDER_TRANSPOSE_EN
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 64; a++) mem[a] = $urandom;
            run_tile($urandom_range(0, 63), 1'($urandom_range(0, 1)), 1'b0);
        end
`endif

        repeat (5) @(negedge clk);
        check("beats_left", 64'(exp_q.size()), 64'(0));
        check("dones_left", 64'(exp_done_n), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
